// File: rtl/mem_stage_if.sv
// Handshake and data buses around the MEM stage of the 5-stage LoongArch pipeline.
// master: the surroundings (EXE, WB, data SRAM) that feed the stage.
// slave:  the mem_stage itself.
interface mem_stage_if #(
  parameter int unsigned EXE_TO_MEM_WD = 156,
  parameter int unsigned MEM_TO_WB_WD  = 152,
  parameter int unsigned MEM_TO_ID_WD  = 41
);
  logic                     mem_allowin;
  logic                     exe_to_mem_valid;
  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus;
  logic                     wb_allowin;
  logic                     mem_to_wb_valid;
  logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus;
  logic                     wb_to_mem_flush_excp_ertn;
  logic                     mem_to_exe_flush_excp_ertn;
  logic [31:0]              data_sram_rdata;

  modport master (
    input  mem_allowin,
    output exe_to_mem_valid,
    output exe_to_mem_bus,
    output wb_allowin,
    input  mem_to_wb_valid,
    input  mem_to_wb_bus,
    input  mem_to_id_bus,
    output wb_to_mem_flush_excp_ertn,
    input  mem_to_exe_flush_excp_ertn,
    output data_sram_rdata
  );

  modport slave (
    output mem_allowin,
    input  exe_to_mem_valid,
    input  exe_to_mem_bus,
    input  wb_allowin,
    output mem_to_wb_valid,
    output mem_to_wb_bus,
    output mem_to_id_bus,
    input  wb_to_mem_flush_excp_ertn,
    output mem_to_exe_flush_excp_ertn,
    input  data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bundle, holds the one-cycle SRAM read data across WB
// stalls, aligns/extends load data and forwards the stage result to ID.
// Optional feature: define MEM_LOAD_FWD_EN to let ID forward load results out of MEM
// (load_pending is then tied to 0).
module mem_stage (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);
  localparam int unsigned EXE_TO_MEM_WD = 156;

  logic                     mem_valid;
  logic [EXE_TO_MEM_WD-1:0] mem_data;
  logic [31:0]              rbuf;
  logic                     rbuf_vld;
  logic                     first_cyc;

  logic        reg_w;
  logic [4:0]  reg_waddr;
  logic        res_from_mem;
  logic [31:0] result;
  logic [1:0]  mem_ins_rec;
  logic        load_sign;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [13:0] csr_num;
  logic [1:0]  csr_inst_rec;
  logic        excp;
  logic        ertn;
  logic [31:0] pc;

  logic        mem_allowin;
  logic        accept;
  logic        flush_in;
  logic [31:0] rdata;
  logic [31:0] rdata_shift;
  logic [31:0] load_value;
  logic [31:0] final_val;
  logic        load_pending;

  assign {reg_w, reg_waddr, res_from_mem, result, mem_ins_rec, load_sign, data_a, data_b,
          csr_num, csr_inst_rec, excp, ertn, pc} = mem_data;

  // The stage never needs extra cycles, so it is always ready to go.
  assign mem_allowin = ~mem_valid | bus.wb_allowin;
  assign accept      = mem_allowin & bus.exe_to_mem_valid;
  assign flush_in    = bus.wb_to_mem_flush_excp_ertn;

  // SRAM data is only valid in the first MEM cycle; after that use the captured copy.
  assign rdata       = rbuf_vld ? rbuf : bus.data_sram_rdata;
  assign rdata_shift = rdata >> {result[1:0], 3'b000};

  // Align and extend the load data according to the access size.
  always_comb begin
    load_value = '0;
    unique case (mem_ins_rec)
      2'b01:   load_value = {{24{load_sign & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b10:   load_value = {{16{load_sign & rdata_shift[15]}}, rdata_shift[15:0]};
      2'b11:   load_value = rdata;
      default: load_value = '0;
    endcase
  end

  // Excepting entries never deliver load data; WB only needs their result/pc.
  assign final_val = (res_from_mem & ~excp & ~ertn) ? load_value : result;

`ifdef MEM_LOAD_FWD_EN
  assign load_pending = 1'b0;
`else
  assign load_pending = mem_valid & res_from_mem;
`endif

  assign bus.mem_allowin     = mem_allowin;
  assign bus.mem_to_wb_valid = mem_valid;
  assign bus.mem_to_wb_bus   = {reg_w, reg_waddr, final_val, data_a, data_b, csr_num,
                                csr_inst_rec, excp, ertn, pc};
  assign bus.mem_to_id_bus   = {mem_valid, reg_w, reg_waddr, final_val, (csr_inst_rec != 2'b00),
                                load_pending};
  assign bus.mem_to_exe_flush_excp_ertn = (mem_valid & (excp | ertn)) | flush_in;

  // Stage occupancy, bundle latch and read-data capture during WB stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_data  <= '0;
      rbuf      <= '0;
      rbuf_vld  <= 1'b0;
      first_cyc <= 1'b0;
    end else begin
      if (flush_in) begin
        mem_valid <= 1'b0;
      end else if (mem_allowin) begin
        mem_valid <= bus.exe_to_mem_valid;
      end
      if (accept) begin
        mem_data <= bus.exe_to_mem_bus;
      end
      first_cyc <= accept;
      if (flush_in | (mem_valid & bus.wb_allowin)) begin
        rbuf_vld <= 1'b0;
      end else if (mem_valid & first_cyc & ~bus.wb_allowin) begin
        rbuf     <= bus.data_sram_rdata;
        rbuf_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage with an entry-level reference model and directed corner cases.
module tb_mem_stage;
  logic clk = 1'b1;
  logic reset;
  logic started = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Model state: what the stage holds and the read data its entry saw on arrival.
  logic         m_valid = 1'b0;
  logic         m_first = 1'b0;
  logic [155:0] m_entry = '0;
  logic [31:0]  m_rdata = '0;

  task automatic chk(input string name, input logic [155:0] act, input logic [155:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an entry given the read data that belongs to it.
  function automatic logic [31:0] exp_final(input logic [155:0] e, input logic [31:0] rd);
    logic        rfm;
    logic [31:0] res;
    logic [1:0]  ins;
    logic        sgn;
    logic [7:0]  b;
    logic [15:0] h;
    rfm = e[149];
    res = e[148:117];
    ins = e[116:115];
    sgn = e[114];
    if (!rfm || e[33] || e[32]) return res;
    b = 8'(rd >> (8 * int'(res[1:0])));
    h = 16'(rd >> (16 * int'(res[1])));
    case (ins)
      2'b01:   return (sgn && b[7]) ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
      2'b10:   return (sgn && h[15]) ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
      2'b11:   return rd;
      default: return 32'h0;
    endcase
  endfunction

  // Compare the outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [31:0] rd;
    logic [31:0] fin;
    logic        lp;
    if (started) begin
      rd  = m_first ? bus_if.data_sram_rdata : m_rdata;
      fin = exp_final(m_entry, rd);
`ifdef MEM_LOAD_FWD_EN
      lp = 1'b0;
`else
      lp = m_entry[149];
`endif
      chk("allowin", 156'(bus_if.mem_allowin), 156'(!m_valid || bus_if.wb_allowin));
      chk("wb_valid", 156'(bus_if.mem_to_wb_valid), 156'(m_valid));
      chk("flush_out", 156'(bus_if.mem_to_exe_flush_excp_ertn),
          156'((m_valid && (m_entry[33] || m_entry[32])) || bus_if.wb_to_mem_flush_excp_ertn));
      chk("id_valid", 156'(bus_if.mem_to_id_bus[40]), 156'(m_valid));
      if (m_valid) begin
        chk("wb_bus", 156'(bus_if.mem_to_wb_bus),
            156'({m_entry[155], m_entry[154:150], fin, m_entry[113:0]}));
        chk("id_bus", 156'(bus_if.mem_to_id_bus),
            156'({1'b1, m_entry[155], m_entry[154:150], fin, (m_entry[35:34] != 2'b00), lp}));
      end
    end
    if (reset) begin
      m_valid = 1'b0;
      m_first = 1'b0;
    end else if (bus_if.wb_to_mem_flush_excp_ertn) begin
      m_valid = 1'b0;
    end else if (!m_valid || bus_if.wb_allowin) begin
      m_valid = bus_if.exe_to_mem_valid;
      if (bus_if.exe_to_mem_valid) begin
        m_entry = bus_if.exe_to_mem_bus;
        m_first = 1'b1;
      end
    end else begin
      if (m_first) m_rdata = bus_if.data_sram_rdata;
      m_first = 1'b0;
    end
  end

  function automatic logic [155:0] mk(input logic [4:0] waddr, input logic rfm,
                                      input logic [31:0] res, input logic [1:0] ins,
                                      input logic sgn, input logic excp);
    return {1'b1, waddr, rfm, res, ins, sgn, 32'($urandom), 32'($urandom), 14'($urandom),
            2'b00, excp, 1'b0, 32'($urandom)};
  endfunction

  function automatic logic [155:0] rand_entry();
    logic [1:0]  ins;
    logic [31:0] res;
    ins = 2'($urandom);
    res = $urandom;
    if (ins == 2'b10) res[0] = 1'b0;
    return {1'($urandom), 5'($urandom), 1'($urandom), res, ins, 1'($urandom), 32'($urandom),
            32'($urandom), 14'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.exe_to_mem_bus = '0;
    bus_if.wb_allowin = 1'b1;
    bus_if.wb_to_mem_flush_excp_ertn = 1'b0;
    bus_if.data_sram_rdata = '0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin", 156'(bus_if.mem_allowin), 156'(1));
    chk("rst_wb_valid", 156'(bus_if.mem_to_wb_valid), 156'(0));
    chk("rst_flush", 156'(bus_if.mem_to_exe_flush_excp_ertn), 156'(0));
    chk("rst_id40", 156'(bus_if.mem_to_id_bus[40]), 156'(0));

    // ld.b, byte 3, signed
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd3, 1'b1, 32'h0000_1003, 2'b01, 1'b1, 1'b0);
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.data_sram_rdata = 32'h80AB_CD12;
    #1;
    chk("ldb_valid", 156'(bus_if.mem_to_wb_valid), 156'(1));
    chk("ldb_final", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'hFFFF_FF80));
    tick();

    // ld.hu then ld.h back to back, halfword 2
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd4, 1'b1, 32'h0000_2002, 2'b10, 1'b0, 1'b0);
    tick();
    bus_if.exe_to_mem_bus = mk(5'd4, 1'b1, 32'h0000_2002, 2'b10, 1'b1, 1'b0);
    bus_if.data_sram_rdata = 32'h8765_4321;
    #1;
    chk("ldhu_final", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'h0000_8765));
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    #1;
    chk("ldh_final", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'hFFFF_8765));
    tick();

    // ld.w held across a 3-cycle WB stall while the SRAM output changes
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd7, 1'b1, 32'h0000_3000, 2'b11, 1'b0, 1'b0);
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_allowin = 1'b0;
    bus_if.data_sram_rdata = 32'h1234_5678;
    #1;
    chk("ldw_stall_allowin", 156'(bus_if.mem_allowin), 156'(0));
    chk("ldw_first", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'h1234_5678));
    for (int i = 0; i < 2; i++) begin
      tick();
      bus_if.data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("ldw_stall_allowin", 156'(bus_if.mem_allowin), 156'(0));
      chk("ldw_stall_final", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'h1234_5678));
    end
    tick();
    bus_if.wb_allowin = 1'b1;
    #1;
    chk("ldw_release_final", 156'(bus_if.mem_to_wb_bus[145:114]), 156'(32'h1234_5678));
    tick();

    // ALU result forwarded to ID
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd5, 1'b0, 32'h0000_00AA, 2'b00, 1'b0, 1'b0);
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    #1;
    chk("alu_id_valid", 156'(bus_if.mem_to_id_bus[40]), 156'(1));
    chk("alu_id_addr", 156'(bus_if.mem_to_id_bus[38:34]), 156'(5));
    chk("alu_id_final", 156'(bus_if.mem_to_id_bus[33:2]), 156'(32'h0000_00AA));
    tick();

    // Exception entry flushes EXE; WB flush beats a same-cycle accept
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd9, 1'b1, 32'h0000_4000, 2'b11, 1'b0, 1'b1);
    tick();
    bus_if.exe_to_mem_bus = rand_entry();
    #1;
    chk("excp_flush_out", 156'(bus_if.mem_to_exe_flush_excp_ertn), 156'(1));
    bus_if.wb_to_mem_flush_excp_ertn = 1'b1;
    tick();
    bus_if.wb_to_mem_flush_excp_ertn = 1'b0;
    bus_if.exe_to_mem_valid = 1'b0;
    #1;
    chk("flush_drop", 156'(bus_if.mem_to_wb_valid), 156'(0));
    tick();

    // Reset in the second cycle of a load stall
    bus_if.exe_to_mem_valid = 1'b1;
    bus_if.exe_to_mem_bus = mk(5'd2, 1'b1, 32'h0000_5000, 2'b11, 1'b0, 1'b0);
    tick();
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_allowin = 1'b0;
    bus_if.data_sram_rdata = 32'hCAFE_F00D;
    tick();
    bus_if.data_sram_rdata = $urandom;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall_valid", 156'(bus_if.mem_to_wb_valid), 156'(0));
    chk("rst_stall_rbuf_vld", 156'(dut.rbuf_vld), 156'(0));
    chk("rst_stall_allowin", 156'(bus_if.mem_allowin), 156'(1));
    bus_if.wb_allowin = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus_if.exe_to_mem_valid = ($urandom_range(0, 9) < 7);
      bus_if.exe_to_mem_bus = rand_entry();
      bus_if.wb_allowin = ($urandom_range(0, 9) < 6);
      bus_if.wb_to_mem_flush_excp_ertn = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 49) == 0);
      bus_if.data_sram_rdata = $urandom;
      tick();
    end
    reset = 1'b0;
    bus_if.exe_to_mem_valid = 1'b0;
    bus_if.wb_to_mem_flush_excp_ertn = 1'b0;
    bus_if.wb_allowin = 1'b1;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
